ecc_rmw_sequencer: RTL and testbench

- Sequences read-modify-write for ECC-protected partial writes, ahead of the ECC merge/encode datapath.
- Full-mask writes go straight to a write command.
- Partial writes first issue a read of the same address. The returned data is captured into the merge register (merge_we), then the write is issued.
- Drives the per-beat raw_not_ecc control one cycle before the write command, because the encoder samples raw_not_ecc registered.

---
 rtl/ecc_rmw_sequencer.sv | 156 +++++++++++++++
 tb/tb_ecc_rmw_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_rmw_sequencer.sv
// Read-modify-write sequencer for ECC-protected partial writes.
// Full-mask writes go straight to a write command; partial writes read, merge, then write.
module ecc_rmw_sequencer #(
  parameter int unsigned ADDR_WIDTH          = 28,
  parameter int unsigned DATA_BUF_ADDR_WIDTH = 4,
  parameter int unsigned nCK_PER_CLK         = 4,
  parameter int unsigned RD_TIMEOUT          = 64,
  parameter int          TCQ                 = 100
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [DATA_BUF_ADDR_WIDTH-1:0]   req_buf_addr,
  input  logic                             req_partial,
  input  logic [2*nCK_PER_CLK-1:0]         req_raw,
  output logic                             rd_cmd_valid,
  input  logic                             rd_cmd_ready,
  output logic [ADDR_WIDTH-1:0]            rd_cmd_addr,
  input  logic                             rd_data_valid,
  input  logic                             rd_data_ue,
  output logic                             merge_we,
  output logic [DATA_BUF_ADDR_WIDTH-1:0]   merge_buf_addr,
  output logic                             wr_cmd_valid,
  input  logic                             wr_cmd_ready,
  output logic [ADDR_WIDTH-1:0]            wr_cmd_addr,
  output logic [DATA_BUF_ADDR_WIDTH-1:0]   wr_cmd_buf_addr,
  output logic [2*nCK_PER_CLK-1:0]         raw_not_ecc,
  output logic                             busy,
  output logic                             err_ue,
  output logic                             err_timeout
);

  localparam int unsigned RAW_W   = 2 * nCK_PER_CLK;
  localparam int unsigned TIMER_W = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(RD_TIMEOUT - 1);

  if (RD_TIMEOUT < 2 || TCQ < 0) begin : g_bad_params
    $error("ecc_rmw_sequencer: RD_TIMEOUT must be >= 2 and TCQ non-negative");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_CMD  = 3'd1,
    RD_WAIT = 3'd2,
    MERGE   = 3'd3,
    WR_CMD  = 3'd4
  } state_t;

  state_t                         state;
  logic [TIMER_W-1:0]             timer;
  logic [ADDR_WIDTH-1:0]          addr_q;
  logic [DATA_BUF_ADDR_WIDTH-1:0] buf_q;
  logic [RAW_W-1:0]               raw_q;

  logic rd_hit;
  logic rd_expired;

  // Read-return qualifiers; merge capture must coincide with the returned burst.
  assign rd_hit      = (state == RD_WAIT) && rd_data_valid;
  assign rd_expired  = (state == RD_WAIT) && !rd_data_valid && (timer == TIMER_LAST);
  assign merge_we    = rd_hit && !rd_data_ue;
  assign err_ue      = rd_hit && rd_data_ue;
  assign err_timeout = rd_expired;

  assign rd_cmd_addr     = addr_q;
  assign wr_cmd_addr     = addr_q;
  assign wr_cmd_buf_addr = buf_q;
  assign merge_buf_addr  = buf_q;
  assign raw_not_ecc     = raw_q;

  // Sequencer state and registered command/handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      timer        <= '0;
      addr_q       <= '0;
      buf_q        <= '0;
      raw_q        <= '0;
      req_ready    <= 1'b0;
      rd_cmd_valid <= 1'b0;
      wr_cmd_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            addr_q    <= req_addr;
            buf_q     <= req_buf_addr;
            raw_q     <= req_raw;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_partial) begin
              state        <= RD_CMD;
              rd_cmd_valid <= 1'b1;
            end else begin
              state <= MERGE;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end

        RD_CMD: begin
          if (rd_cmd_ready) begin
            rd_cmd_valid <= 1'b0;
            timer        <= '0;
            state        <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          timer <= timer + TIMER_W'(1);
          // Returned data takes priority over an expiring timer.
          if (rd_data_valid) begin
            if (rd_data_ue) begin
              state     <= IDLE;
              busy      <= 1'b0;
              req_ready <= 1'b1;
            end else begin
              state <= MERGE;
            end
          end else if (timer == TIMER_LAST) begin
            state     <= IDLE;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end

        MERGE: begin
          state        <= WR_CMD;
          wr_cmd_valid <= 1'b1;
        end

        WR_CMD: begin
          if (wr_cmd_ready) begin
            wr_cmd_valid <= 1'b0;
            state        <= IDLE;
            busy         <= 1'b0;
            req_ready    <= 1'b1;
          end
        end

        default: begin
          state        <= IDLE;
          rd_cmd_valid <= 1'b0;
          wr_cmd_valid <= 1'b0;
          busy         <= 1'b0;
          req_ready    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_rmw_sequencer.sv
// Scoreboard bench for ecc_rmw_sequencer: directed requests push expectations, a monitor pops them.
module tb_ecc_rmw_sequencer;

  localparam int unsigned AW = 28;
  localparam int unsigned BW = 4;
  localparam int unsigned RW = 8;
  localparam int unsigned TO = 8;
  localparam logic [1:0] E_UE = 2'b01;
  localparam logic [1:0] E_TO = 2'b10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req_valid, req_ready, req_partial;
  logic [AW-1:0] req_addr;
  logic [BW-1:0] req_buf_addr;
  logic [RW-1:0] req_raw;
  logic          rd_cmd_valid, rd_cmd_ready;
  logic [AW-1:0] rd_cmd_addr;
  logic          rd_data_valid, rd_data_ue;
  logic          merge_we;
  logic [BW-1:0] merge_buf_addr;
  logic          wr_cmd_valid, wr_cmd_ready;
  logic [AW-1:0] wr_cmd_addr;
  logic [BW-1:0] wr_cmd_buf_addr;
  logic [RW-1:0] raw_not_ecc;
  logic          busy, err_ue, err_timeout;

  ecc_rmw_sequencer #(
    .ADDR_WIDTH(AW), .DATA_BUF_ADDR_WIDTH(BW), .nCK_PER_CLK(RW/2),
    .RD_TIMEOUT(TO), .TCQ(100)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_buf_addr(req_buf_addr), .req_partial(req_partial), .req_raw(req_raw),
    .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready), .rd_cmd_addr(rd_cmd_addr),
    .rd_data_valid(rd_data_valid), .rd_data_ue(rd_data_ue),
    .merge_we(merge_we), .merge_buf_addr(merge_buf_addr),
    .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready), .wr_cmd_addr(wr_cmd_addr),
    .wr_cmd_buf_addr(wr_cmd_buf_addr), .raw_not_ecc(raw_not_ecc),
    .busy(busy), .err_ue(err_ue), .err_timeout(err_timeout)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [BW-1:0] buf_a;
    logic [RW-1:0] raw;
  } wr_exp_t;

  wr_exp_t       wr_q[$];
  logic [AW-1:0] rd_q[$];
  logic [BW-1:0] mg_q[$];
  logic [1:0]    err_q[$];

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_ctl"}, 64'({req_ready, busy, rd_cmd_valid, wr_cmd_valid, merge_we,
                              err_ue, err_timeout, raw_not_ecc}), 64'(0));
    check({name, "_addr"}, 64'({rd_cmd_addr, wr_cmd_buf_addr}), 64'(0));
  endtask

  // Waits (bounded) for req_ready, presents one request for one cycle; returns in cycle T+1.
  task automatic accept(input logic [AW-1:0] a, input logic [BW-1:0] b,
                        input logic p, input logic [RW-1:0] r);
    int n = 0;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    check("accept_ready", 64'(req_ready), 64'(1));
    req_valid    = 1'b1;
    req_addr     = a;
    req_buf_addr = b;
    req_partial  = p;
    req_raw      = r;
    step();
    req_valid = 1'b0;
  endtask

  // Monitor: every DUT output event pops and checks the next expectation.
  wr_exp_t    mon_wr;
  logic [1:0] mon_err;
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_cmd_valid && wr_cmd_valid) check("cmd_exclusive", 64'(1), 64'(0));
      if (rd_cmd_valid && rd_cmd_ready) begin
        if (rd_q.size() == 0) check("unexpected_rd_cmd", 64'(1), 64'(0));
        else check("rd_cmd_addr", 64'(rd_cmd_addr), 64'(rd_q.pop_front()));
      end
      if (merge_we) begin
        check("merge_with_data", 64'(rd_data_valid), 64'(1));
        if (mg_q.size() == 0) check("unexpected_merge_we", 64'(1), 64'(0));
        else check("merge_buf_addr", 64'(merge_buf_addr), 64'(mg_q.pop_front()));
      end
      if (wr_cmd_valid && wr_cmd_ready) begin
        if (wr_q.size() == 0) check("unexpected_wr_cmd", 64'(1), 64'(0));
        else begin
          mon_wr = wr_q.pop_front();
          check("wr_cmd_addr", 64'(wr_cmd_addr), 64'(mon_wr.addr));
          check("wr_cmd_buf_addr", 64'(wr_cmd_buf_addr), 64'(mon_wr.buf_a));
          check("wr_raw_not_ecc", 64'(raw_not_ecc), 64'(mon_wr.raw));
        end
      end
      if (err_ue || err_timeout) begin
        if (err_q.size() == 0) check("unexpected_err", 64'({err_timeout, err_ue}), 64'(0));
        else begin
          mon_err = err_q.pop_front();
          check("err_kind", 64'({err_timeout, err_ue}), 64'(mon_err));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual timeout required finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_buf_addr = '0; req_partial = 1'b0; req_raw = '0;
    rd_cmd_ready = 1'b0; rd_data_valid = 1'b0; rd_data_ue = 1'b0; wr_cmd_ready = 1'b0;
    step(); step();
    check_outputs_zero("reset_state");
    rst = 1'b0;
    check("req_ready_during_release", 64'(req_ready), 64'(0));
    step();
    check("req_ready_after_reset", 64'(req_ready), 64'(1));

    // Full write: wr_cmd_valid at T+2, req_ready back the cycle after the handshake.
    wr_cmd_ready = 1'b1;
    wr_q.push_back('{addr: 28'h10, buf_a: 4'd3, raw: 8'h00});
    accept(28'h10, 4'd3, 1'b0, 8'h00);
    check("full_t1", 64'({req_ready, busy, rd_cmd_valid, wr_cmd_valid}), 64'(4'b0100));
    step();
    check("full_t2_wr_valid", 64'({rd_cmd_valid, wr_cmd_valid}), 64'(2'b01));
    step();
    check("full_t3_idle", 64'({req_ready, busy, wr_cmd_valid}), 64'(3'b100));

    // Partial write, read command stalled 3 cycles, data 5 cycles after read accept.
    wr_cmd_ready = 1'b0;
    rd_q.push_back(28'h0ABCDEF);
    mg_q.push_back(4'd9);
    wr_q.push_back('{addr: 28'h0ABCDEF, buf_a: 4'd9, raw: 8'hA5});
    check("raw_before_accept", 64'(raw_not_ecc), 64'(8'h00));
    accept(28'h0ABCDEF, 4'd9, 1'b1, 8'hA5);
    check("raw_loaded_on_accept", 64'(raw_not_ecc), 64'(8'hA5));
    for (int i = 0; i < 3; i++) begin
      check("rd_cmd_stall_hold", 64'({rd_cmd_valid, rd_cmd_addr}), 64'({1'b1, 28'h0ABCDEF}));
      step();
    end
    check("rd_cmd_4th_cycle", 64'({rd_cmd_valid, rd_cmd_addr}), 64'({1'b1, 28'h0ABCDEF}));
    rd_cmd_ready = 1'b1;
    step();
    rd_cmd_ready = 1'b0;
    check("rd_wait_entered", 64'({busy, rd_cmd_valid}), 64'(2'b10));
    for (int i = 0; i < 4; i++) begin
      check("no_early_merge", 64'(merge_we), 64'(0));
      step();
    end
    rd_data_valid = 1'b1;
    #1;
    check("merge_we_with_data", 64'({merge_we, merge_buf_addr}), 64'({1'b1, 4'd9}));
    step();
    rd_data_valid = 1'b0;
    check("merge_cycle", 64'({merge_we, wr_cmd_valid, raw_not_ecc}), 64'({2'b00, 8'hA5}));
    step();
    for (int i = 0; i < 2; i++) begin
      check("wr_stall_hold", 64'({wr_cmd_valid, raw_not_ecc, wr_cmd_buf_addr}),
            64'({1'b1, 8'hA5, 4'd9}));
      step();
    end
    wr_cmd_ready = 1'b1;
    check("wr_handshake_cycle", 64'({wr_cmd_valid, raw_not_ecc}), 64'({1'b1, 8'hA5}));
    step();
    check("partial_done", 64'({req_ready, busy, wr_cmd_valid}), 64'(3'b100));

    // UE on returned data aborts; a lone rd_data_ue is ignored.
    rd_cmd_ready = 1'b1;
    rd_q.push_back(28'h0000200);
    err_q.push_back(E_UE);
    accept(28'h0000200, 4'd5, 1'b1, 8'h0F);
    step();
    rd_data_ue = 1'b1;
    #1;
    check("ue_without_valid", 64'({err_ue, merge_we}), 64'(0));
    step();
    rd_data_valid = 1'b1;
    #1;
    check("ue_pulse", 64'({err_ue, merge_we, err_timeout}), 64'(3'b100));
    step();
    rd_data_valid = 1'b0; rd_data_ue = 1'b0;
    check("ue_aborted", 64'({busy, req_ready, err_ue, wr_cmd_valid}), 64'(4'b0100));

    // Timeout after RD_TIMEOUT cycles; late data ignored.
    rd_q.push_back(28'h0000300);
    err_q.push_back(E_TO);
    accept(28'h0000300, 4'd6, 1'b1, 8'h11);
    step();
    for (int i = 0; i < 7; i++) begin
      check("no_early_timeout", 64'(err_timeout), 64'(0));
      step();
    end
    check("timeout_pulse", 64'({err_timeout, busy}), 64'(2'b11));
    step();
    check("timeout_idle", 64'({err_timeout, busy, req_ready}), 64'(3'b001));
    rd_data_valid = 1'b1;
    #1;
    check("late_data_ignored", 64'(merge_we), 64'(0));
    step();
    rd_data_valid = 1'b0;

    // Data in the same cycle as the timeout condition wins.
    rd_q.push_back(28'h0000400);
    mg_q.push_back(4'd7);
    wr_q.push_back('{addr: 28'h0000400, buf_a: 4'd7, raw: 8'h5A});
    accept(28'h0000400, 4'd7, 1'b1, 8'h5A);
    step();
    for (int i = 0; i < 7; i++) step();
    rd_data_valid = 1'b1;
    #1;
    check("data_beats_timeout", 64'({merge_we, err_timeout}), 64'(2'b10));
    step();
    rd_data_valid = 1'b0;
    step();
    check("boundary_write", 64'(wr_cmd_valid), 64'(1));
    step();

    // Reset during RD_WAIT discards the request.
    rd_q.push_back(28'h0000500);
    accept(28'h0000500, 4'd2, 1'b1, 8'h3C);
    step(); step();
    rst = 1'b1;
    step();
    check_outputs_zero("rst_in_rd_wait");
    rst = 1'b0;
    check("rd_wait_rst_release", 64'(req_ready), 64'(0));
    step();
    check("rd_wait_rst_ready", 64'({req_ready, busy}), 64'(2'b10));
    rd_data_valid = 1'b1;
    step();
    rd_data_valid = 1'b0;

    // Reset during a stalled write command.
    wr_cmd_ready = 1'b0;
    accept(28'h0000600, 4'd4, 1'b0, 8'hC3);
    step();
    check("wr_stall_before_rst", 64'(wr_cmd_valid), 64'(1));
    step();
    rst = 1'b1;
    step();
    check_outputs_zero("rst_in_wr_cmd");
    rst = 1'b0;
    wr_cmd_ready = 1'b1;
    step();
    check("wr_rst_ready", 64'({req_ready, wr_cmd_valid}), 64'(2'b10));
    step(); step();

    // Recovery: an ordinary full write still works.
    wr_q.push_back('{addr: 28'hFFFFFFF, buf_a: 4'hF, raw: 8'hFF});
    accept(28'hFFFFFFF, 4'hF, 1'b0, 8'hFF);
    step();
    check("recover_wr_valid", 64'(wr_cmd_valid), 64'(1));
    step();
    step();

    check("queues_drained", 64'(wr_q.size() + rd_q.size() + mg_q.size() + err_q.size()), 64'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
